// File: rtl/sar_pkg.sv
// Shared types and helpers for the parametrised SAR conversion controller.
package sar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_SAMPLE  = 2'b01,
        ST_CONVERT = 2'b10,
        ST_DONE    = 2'b11
    } sar_state_t;

    // Comparator level meaning "input >= DAC", i.e. keep the trial bit.
    localparam logic VCOMP_KEEP = 1'b1;

    // Counter width able to hold values 0..n-1, never narrower than one bit.
    function automatic int sar_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sar_register.sv
// Trial/result register: clear, per-bit set from the comparator, and DAC code merge.
module sar_register
    import sar_pkg::*;
#(
    parameter int NBITS = 8,
    parameter int IDXW  = 3
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             clr,
    input  logic             wr,
    input  logic [IDXW-1:0]  wr_idx,
    input  logic             vcomp,
    input  logic             code_en,
    input  logic             probe_en,
    input  logic [IDXW-1:0]  probe_idx,
    output logic [NBITS-1:0] trial_next,
    output logic [NBITS-1:0] probe_onehot,
    output logic [NBITS-1:0] dac_code
);

    logic [NBITS-1:0] trial_reg;
    logic [NBITS-1:0] dac_code_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NBITS; gi++) begin : g_bit
            assign trial_next[gi]   = clr ? 1'b0 :
                                      (wr && (wr_idx == IDXW'(gi))) ? (vcomp == VCOMP_KEEP) :
                                      trial_reg[gi];
            assign probe_onehot[gi] = probe_en && (probe_idx == IDXW'(gi));
        end
    endgenerate

    // The DAC sees resolved upper bits plus the bit under trial, already registered.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            trial_reg    <= '0;
            dac_code_reg <= '0;
        end else begin
            trial_reg    <= trial_next;
            dac_code_reg <= code_en ? (trial_next | probe_onehot) : '0;
        end
    end

    assign dac_code = dac_code_reg;

endmodule

// File: rtl/sar_ctrl_param.sv
// Parametrised SAR ADC controller: sample, MSB-first binary search, registered result.
module sar_ctrl_param
    import sar_pkg::*;
#(
    parameter int NBITS         = 8,
    parameter int SAMPLE_CYCLES = 1
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             START,
    input  logic             CONT,
    input  logic             ABORT,
    input  logic             VCOMP,
    output logic [NBITS-1:0] DAC_CODE,
    output logic [NBITS-1:0] OUTEN,
    output logic             SAR_RESET,
    output logic             BUSY,
    output logic [NBITS-1:0] DATA,
    output logic             DATA_VALID
);

    localparam int IDXW = sar_width(NBITS);
    localparam int SCW  = sar_width(SAMPLE_CYCLES + 1);

    sar_state_t       state_reg, state_next;
    logic [SCW-1:0]   samp_cnt_reg, samp_cnt_next;
    logic [IDXW-1:0]  bit_idx_reg, bit_idx_next;
    logic [NBITS-1:0] data_reg, data_next;
    logic [NBITS-1:0] outen_reg;
    logic             sar_reset_reg, busy_reg, data_valid_reg;

    logic             clr, wr, code_en, probe_en;
    logic [NBITS-1:0] trial_next, probe_onehot;

    sar_register #(
        .NBITS (NBITS),
        .IDXW  (IDXW)
    ) u_reg (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .clr          (clr),
        .wr           (wr),
        .wr_idx       (bit_idx_reg),
        .vcomp        (VCOMP),
        .code_en      (code_en),
        .probe_en     (probe_en),
        .probe_idx    (bit_idx_next),
        .trial_next   (trial_next),
        .probe_onehot (probe_onehot),
        .dac_code     (DAC_CODE)
    );

    always_comb begin
        state_next    = state_reg;
        samp_cnt_next = samp_cnt_reg;
        bit_idx_next  = bit_idx_reg;
        data_next     = data_reg;
        clr           = 1'b0;
        wr            = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (START) begin
                    state_next    = ST_SAMPLE;
                    samp_cnt_next = SCW'(SAMPLE_CYCLES);
                    clr           = 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (samp_cnt_reg == SCW'(1)) begin
                    state_next   = ST_CONVERT;
                    bit_idx_next = IDXW'(NBITS - 1);
                end else begin
                    samp_cnt_next = samp_cnt_reg - SCW'(1);
                end
            end
            ST_CONVERT: begin
                wr = 1'b1;
                if (bit_idx_reg == '0) begin
                    state_next = ST_DONE;
                    data_next  = trial_next;
                end else begin
                    bit_idx_next = bit_idx_reg - IDXW'(1);
                end
            end
            ST_DONE: begin
                if (CONT || START) begin
                    state_next    = ST_SAMPLE;
                    samp_cnt_next = SCW'(SAMPLE_CYCLES);
                    clr           = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Abort overrides everything, including the result capture on the last bit.
        if (ABORT) begin
            state_next = ST_IDLE;
            data_next  = data_reg;
            wr         = 1'b0;
            clr        = 1'b0;
        end
    end

    assign code_en  = (state_next == ST_CONVERT) || (state_next == ST_DONE);
    assign probe_en = (state_next == ST_CONVERT);

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg      <= ST_IDLE;
            samp_cnt_reg   <= '0;
            bit_idx_reg    <= '0;
            data_reg       <= '0;
            outen_reg      <= '0;
            sar_reset_reg  <= 1'b0;
            busy_reg       <= 1'b0;
            data_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            samp_cnt_reg   <= samp_cnt_next;
            bit_idx_reg    <= bit_idx_next;
            data_reg       <= data_next;
            outen_reg      <= probe_onehot;
            sar_reset_reg  <= (state_next == ST_SAMPLE);
            busy_reg       <= (state_next == ST_SAMPLE) || (state_next == ST_CONVERT);
            data_valid_reg <= (state_next == ST_DONE);
        end
    end

    assign OUTEN      = outen_reg;
    assign SAR_RESET  = sar_reset_reg;
    assign BUSY       = busy_reg;
    assign DATA       = data_reg;
    assign DATA_VALID = data_valid_reg;

endmodule

// File: tb/tb_sar_ctrl_param.sv
// Bench for sar_ctrl_param: ideal comparator model and per-cycle expected outputs.
module tb_sar_ctrl_param;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;

    logic        start8 = 1'b0, cont8 = 1'b0, abort8 = 1'b0;
    logic [7:0]  target8 = 8'h00;
    logic [7:0]  dac8, outen8, data8;
    logic        sar_reset8, busy8, dv8, vcomp8;

    logic        start12 = 1'b0, cont12 = 1'b0, abort12 = 1'b0;
    logic [11:0] target12 = 12'h000;
    logic [11:0] dac12, outen12, data12;
    logic        sar_reset12, busy12, dv12, vcomp12;

    logic [50:0] obs8, obs12, expv;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          last8   = 0;

    always #5 clk = ~clk;

    // Ideal comparator: analog input >= DAC output.
    assign vcomp8  = (target8 >= dac8);
    assign vcomp12 = (target12 >= dac12);

    assign obs8  = {sar_reset8, busy8, 8'h00, outen8, 8'h00, dac8, dv8, 8'h00, data8};
    assign obs12 = {sar_reset12, busy12, 4'h0, outen12, 4'h0, dac12, dv12, 4'h0, data12};

    sar_ctrl_param dut8 (
        .CLK(clk), .RESET_N(rst_n), .START(start8), .CONT(cont8), .ABORT(abort8),
        .VCOMP(vcomp8), .DAC_CODE(dac8), .OUTEN(outen8), .SAR_RESET(sar_reset8),
        .BUSY(busy8), .DATA(data8), .DATA_VALID(dv8)
    );

    sar_ctrl_param #(.NBITS(12), .SAMPLE_CYCLES(3)) dut12 (
        .CLK(clk), .RESET_N(rst_n), .START(start12), .CONT(cont12), .ABORT(abort12),
        .VCOMP(vcomp12), .DAC_CODE(dac12), .OUTEN(outen12), .SAR_RESET(sar_reset12),
        .BUSY(busy12), .DATA(data12), .DATA_VALID(dv12)
    );

    // Expected {SAR_RESET, BUSY, OUTEN, DAC_CODE, DATA_VALID, DATA} in cycle c after
    // the accepting edge. With an ideal comparator the bits resolved above k equal the
    // target's own bits, so each trial code is the target truncated above k plus bit k.
    function automatic logic [50:0] exp_out(input int c, input int nb, input int sc,
                                            input int t, input int prev);
        int k;
        logic [15:0] ob, code, tv, pv;
        tv = t[15:0];
        pv = prev[15:0];
        if (c >= 1 && c <= sc) begin
            return {2'b11, 32'h0, 1'b0, pv};
        end else if (c > sc && c <= sc + nb) begin
            k    = nb - 1 - (c - sc - 1);
            ob   = 16'(1 << k);
            code = 16'(((t >> (k + 1)) << (k + 1)) | (1 << k));
            return {2'b01, ob, code, 1'b0, pv};
        end else if (c == sc + nb + 1) begin
            return {2'b00, 16'h0, tv, 1'b1, tv};
        end
        return {2'b00, 32'h0, 1'b0, tv};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start8(input logic [7:0] t);
        target8 = t;
        start8  = 1'b1;
        tick();
        start8  = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_tests++;
        if (obs8 !== 51'h0) begin
            n_fail++;
            $display("FAIL reset8 got %h exp %h", obs8, 51'h0);
        end
        n_tests++;
        if (obs12 !== 51'h0) begin
            n_fail++;
            $display("FAIL reset12 got %h exp %h", obs12, 51'h0);
        end
        rst_n = 1'b1;
        tick();
        n_tests++;
        if (obs8 !== 51'h0) begin
            n_fail++;
            $display("FAIL idle_after_reset got %h exp %h", obs8, 51'h0);
        end
        $display("[TB] reset: outputs idle");
    endtask

    task automatic test_basic();
        pulse_start8(8'hA5);
        for (int c = 1; c <= 11; c++) begin
            expv = exp_out(c, 8, 1, 'hA5, last8);
            n_tests++;
            if (obs8 !== expv) begin
                n_fail++;
                $display("FAIL basic_a5 c=%0d got %h exp %h", c, obs8, expv);
            end
            tick();
        end
        last8 = 'hA5;
        $display("[TB] basic: target a5 data %h", data8);
    endtask

    task automatic test_extremes();
        logic [7:0] tv [2];
        tv[0] = 8'h00;
        tv[1] = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            pulse_start8(tv[i]);
            for (int c = 1; c <= 11; c++) begin
                expv = exp_out(c, 8, 1, int'(tv[i]), last8);
                n_tests++;
                if (obs8 !== expv) begin
                    n_fail++;
                    $display("FAIL extreme t=%h c=%0d got %h exp %h", tv[i], c, obs8, expv);
                end
                tick();
            end
            last8 = int'(tv[i]);
            $display("[TB] extreme: target %h data %h", tv[i], data8);
        end
    endtask

    task automatic test_random();
        logic [7:0] t;
        for (int i = 0; i < 6; i++) begin
            t = 8'($urandom_range(0, 255));
            pulse_start8(t);
            for (int c = 1; c <= 11; c++) begin
                expv = exp_out(c, 8, 1, int'(t), last8);
                n_tests++;
                if (obs8 !== expv) begin
                    n_fail++;
                    $display("FAIL random t=%h c=%0d got %h exp %h", t, c, obs8, expv);
                end
                // One pass holds START high while busy; it must be ignored.
                start8 = (i == 2 && c < 10);
                tick();
            end
            last8 = int'(t);
            $display("[TB] random: target %h data %h", t, data8);
        end
    endtask

    task automatic test_cont();
        cont8 = 1'b1;
        pulse_start8(8'h3C);
        for (int c = 1; c <= 10; c++) begin
            expv = exp_out(c, 8, 1, 'h3C, last8);
            n_tests++;
            if (obs8 !== expv) begin
                n_fail++;
                $display("FAIL cont_first c=%0d got %h exp %h", c, obs8, expv);
            end
            if (c == 10) target8 = 8'hC3;
            tick();
        end
        last8 = 'h3C;
        for (int c = 1; c <= 11; c++) begin
            expv = exp_out(c, 8, 1, 'hC3, last8);
            n_tests++;
            if (obs8 !== expv) begin
                n_fail++;
                $display("FAIL cont_second c=%0d got %h exp %h", c, obs8, expv);
            end
            if (c == 10) cont8 = 1'b0;
            tick();
        end
        last8 = 'hC3;
        $display("[TB] cont: results 3c then %h", data8);
    endtask

    task automatic test_abort();
        pulse_start8(8'h11);
        for (int c = 1; c <= 11; c++) tick();
        n_tests++;
        if (data8 !== 8'h11) begin
            n_fail++;
            $display("FAIL abort_prior got %h exp %h", data8, 8'h11);
        end
        last8 = 'h11;
        pulse_start8(8'h5A);
        for (int c = 1; c <= 5; c++) begin
            expv = exp_out(c, 8, 1, 'h5A, last8);
            n_tests++;
            if (obs8 !== expv) begin
                n_fail++;
                $display("FAIL abort_pre c=%0d got %h exp %h", c, obs8, expv);
            end
            if (c < 5) tick();
        end
        abort8 = 1'b1;
        tick();
        abort8 = 1'b0;
        for (int c = 0; c < 6; c++) begin
            expv = exp_out(0, 8, 1, 'h11, 0);
            n_tests++;
            if (obs8 !== expv) begin
                n_fail++;
                $display("FAIL abort_convert c=%0d got %h exp %h", c, obs8, expv);
            end
            tick();
        end
        $display("[TB] abort: convert aborted, data %h", data8);

        start8 = 1'b1;
        abort8 = 1'b1;
        tick();
        start8 = 1'b0;
        abort8 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            expv = exp_out(0, 8, 1, 'h11, 0);
            n_tests++;
            if (obs8 !== expv) begin
                n_fail++;
                $display("FAIL abort_start_idle c=%0d got %h exp %h", c, obs8, expv);
            end
            tick();
        end
        $display("[TB] abort: abort with start stays idle");

        cont8 = 1'b1;
        pulse_start8(8'h77);
        for (int c = 1; c <= 10; c++) begin
            expv = exp_out(c, 8, 1, 'h77, last8);
            n_tests++;
            if (obs8 !== expv) begin
                n_fail++;
                $display("FAIL abort_done_pre c=%0d got %h exp %h", c, obs8, expv);
            end
            if (c == 10) abort8 = 1'b1;
            tick();
        end
        abort8 = 1'b0;
        cont8  = 1'b0;
        last8  = 'h77;
        for (int c = 0; c < 3; c++) begin
            expv = exp_out(0, 8, 1, 'h77, 0);
            n_tests++;
            if (obs8 !== expv) begin
                n_fail++;
                $display("FAIL abort_done c=%0d got %h exp %h", c, obs8, expv);
            end
            tick();
        end
        $display("[TB] abort: done pulse kept, no restart, data %h", data8);
    endtask

    task automatic test_async_reset();
        logic [7:0] t;
        t = 8'($urandom_range(0, 255));
        pulse_start8(t);
        for (int c = 1; c <= 4; c++) tick();
        #3 rst_n = 1'b0;
        #1;
        n_tests++;
        if (obs8 !== 51'h0) begin
            n_fail++;
            $display("FAIL async_reset got %h exp %h", obs8, 51'h0);
        end
        #2 rst_n = 1'b1;
        tick();
        n_tests++;
        if (obs8 !== 51'h0) begin
            n_fail++;
            $display("FAIL async_release got %h exp %h", obs8, 51'h0);
        end
        last8 = 0;
        t = 8'($urandom_range(0, 255));
        pulse_start8(t);
        for (int c = 1; c <= 11; c++) begin
            expv = exp_out(c, 8, 1, int'(t), last8);
            n_tests++;
            if (obs8 !== expv) begin
                n_fail++;
                $display("FAIL after_reset t=%h c=%0d got %h exp %h", t, c, obs8, expv);
            end
            tick();
        end
        last8 = int'(t);
        $display("[TB] async reset: recovered, target %h data %h", t, data8);
    endtask

    task automatic test_wide();
        logic [11:0] tv [2];
        int          prev;
        tv[0] = 12'hABC;
        tv[1] = 12'($urandom_range(0, 4095));
        prev  = 0;
        for (int i = 0; i < 2; i++) begin
            target12 = tv[i];
            start12  = 1'b1;
            tick();
            start12  = 1'b0;
            for (int c = 1; c <= 17; c++) begin
                expv = exp_out(c, 12, 3, int'(tv[i]), prev);
                n_tests++;
                if (obs12 !== expv) begin
                    n_fail++;
                    $display("FAIL wide t=%h c=%0d got %h exp %h", tv[i], c, obs12, expv);
                end
                tick();
            end
            prev = int'(tv[i]);
            $display("[TB] wide: target %h data %h", tv[i], data12);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_random();
        test_cont();
        test_abort();
        test_async_reset();
        test_wide();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired after %0d tests", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
